uart_byte_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_rx_baud_gen.sv | 55 +++++
 rtl/uart_byte_rx.sv | 165 ++++++++++++++++
 tb/tb_uart_byte_rx.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART byte receiver: baud_set encodings, oversample
// ratio, receive FSM state encodings and the baud divisor constant function.
// No ports; imported by uart_rx_baud_gen and uart_byte_rx.
package uart_pkg;

  // Samples per bit; the voter and sample index counter assume 16.
  localparam int unsigned OVERSAMPLE = 16;

  // baud_set encodings; any other value falls back to 9600.
  localparam logic [2:0] BAUD_9600   = 3'd0;
  localparam logic [2:0] BAUD_19200  = 3'd1;
  localparam logic [2:0] BAUD_38400  = 3'd2;
  localparam logic [2:0] BAUD_57600  = 3'd3;
  localparam logic [2:0] BAUD_115200 = 3'd4;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_BREAK
  } rx_state_e;

  // Clocks per oversample tick, truncated.
  function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_rx_baud_gen.sv
// 16x oversample tick generator: selects the divisor for the latched baud code and
// runs a counter 0..DIV-1 that emits tick_o on DIV-1 while enabled.
// Ports: clk, reset_n, baud_sel_i (baud code), en_i (count), clr_i (sync clear), tick_o.
module uart_rx_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] baud_sel_i,
  input  logic       en_i,
  input  logic       clr_i,
  output logic       tick_o
);

  localparam logic [15:0] DIV_9600_M1   = 16'(baud_div(CLK_FREQ, 9600) - 1);
  localparam logic [15:0] DIV_19200_M1  = 16'(baud_div(CLK_FREQ, 19200) - 1);
  localparam logic [15:0] DIV_38400_M1  = 16'(baud_div(CLK_FREQ, 38400) - 1);
  localparam logic [15:0] DIV_57600_M1  = 16'(baud_div(CLK_FREQ, 57600) - 1);
  localparam logic [15:0] DIV_115200_M1 = 16'(baud_div(CLK_FREQ, 115200) - 1);

  logic [15:0] div_m1;
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    case (baud_sel_i)
      BAUD_19200:  div_m1 = DIV_19200_M1;
      BAUD_38400:  div_m1 = DIV_38400_M1;
      BAUD_57600:  div_m1 = DIV_57600_M1;
      BAUD_115200: div_m1 = DIV_115200_M1;
      default:     div_m1 = DIV_9600_M1;
    endcase
  end

  assign tick_o = en_i && (cnt_q == div_m1);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || tick_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_byte_rx.sv
// UART 8N1 byte receiver: 2-FF synchronizer, 16x oversampling, 3-sample majority
// vote per bit, one byte per frame with 1-cycle rx_done / frame_err / parity_err strobes.
// Ports: clk, reset_n, baud_set, uart_rx in; data_byte, rx_done, frame_err,
// parity_err, uart_state out. Define UART_RX_PARITY_EN to expect a parity bit after D7.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] baud_set,
  input  logic       uart_rx,
  output logic [7:0] data_byte,
  output logic       rx_done,
  output logic       frame_err,
  output logic       parity_err,
  output logic       uart_state
);

  logic [1:0] sync_q;
  logic       rx_prev_q;
  rx_state_e  state_q;
  logic [2:0] baud_q;
  logic [3:0] samp_q;
  logic [2:0] bit_q;
  logic       v7_q, v8_q;
  logic [7:0] shift_q;

  logic rx_s, fall, start_clr, tick, vote, decide;

  assign rx_s      = sync_q[1];
  assign fall      = rx_prev_q & ~rx_s;
  assign start_clr = (state_q == RX_IDLE) && fall;
  // Samples 7 and 8 are held; sample 9 is the live line at the deciding tick.
  assign vote      = (v7_q & v8_q) | (v7_q & rx_s) | (v8_q & rx_s);
  assign decide    = tick && (samp_q == 4'd9);

  uart_rx_baud_gen #(
    .CLK_FREQ(CLK_FREQ)
  ) u_baud_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .baud_sel_i(baud_q),
    .en_i      (uart_state),
    .clr_i     (start_clr),
    .tick_o    (tick)
  );

`ifdef UART_RX_PARITY_EN
  logic par_bad_q;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD[0];
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q     <= 2'b11;
      rx_prev_q  <= 1'b1;
      state_q    <= RX_IDLE;
      baud_q     <= BAUD_9600;
      samp_q     <= '0;
      bit_q      <= '0;
      v7_q       <= 1'b1;
      v8_q       <= 1'b1;
      shift_q    <= '0;
      data_byte  <= '0;
      rx_done    <= 1'b0;
      frame_err  <= 1'b0;
      uart_state <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q  <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      sync_q    <= {sync_q[0], uart_rx};
      rx_prev_q <= rx_s;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (tick) begin
        samp_q <= samp_q + 4'd1;
        if (samp_q == 4'd7) v7_q <= rx_s;
        if (samp_q == 4'd8) v8_q <= rx_s;
      end

      case (state_q)
        RX_IDLE: begin
          if (fall) begin
            state_q    <= RX_START;
            uart_state <= 1'b1;
            baud_q     <= baud_set;
            samp_q     <= '0;
            bit_q      <= '0;
          end
        end
        RX_START: begin
          if (decide) begin
            if (vote) begin
              state_q    <= RX_IDLE;  // glitch, not a start bit
              uart_state <= 1'b0;
            end else begin
              state_q <= RX_DATA;
            end
          end
        end
        RX_DATA: begin
          if (decide) begin
            shift_q <= {vote, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= RX_PARITY;
`else
              state_q <= RX_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        RX_PARITY: begin
          if (decide) begin
            par_bad_q <= ((^shift_q) ^ vote) != PARITY_ODD[0];
            state_q   <= RX_STOP;
          end
        end
`endif
        RX_STOP: begin
          // Leaving at mid stop bit leaves half a bit to catch a back-to-back start edge.
          if (decide) begin
            if (vote) begin
              data_byte  <= shift_q;
              rx_done    <= 1'b1;
`ifdef UART_RX_PARITY_EN
              parity_err <= par_bad_q;
`endif
              state_q    <= RX_IDLE;
              uart_state <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state_q   <= RX_BREAK;
            end
          end
        end
        RX_BREAK: begin
          // A held-low line must not be read as a new start edge.
          if (rx_s) begin
            state_q    <= RX_IDLE;
            uart_state <= 1'b0;
          end
        end
        default: begin
          state_q    <= RX_IDLE;
          uart_state <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx at 50 MHz: drives serial frames on uart_rx and
// checks strobes, received bytes, false-start rejection, framing error, reset abort
// and other baud rates against hand-computed values.
module tb_uart_byte_rx;

  localparam int BT  = 432;  // clk per bit at 115200
  localparam int BT3 = 868;  // clk per bit at 57600, nominal transmitter rate
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] baud_set = 3'd4;
  logic       uart_rx = 1'b1;
  logic [7:0] data_byte;
  logic       rx_done, frame_err, parity_err, uart_state;

  always #10 clk = ~clk;

  uart_byte_rx #(
    .CLK_FREQ  (50_000_000),
    .PARITY_ODD(0)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .baud_set  (baud_set),
    .uart_rx   (uart_rx),
    .data_byte (data_byte),
    .rx_done   (rx_done),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .uart_state(uart_state)
  );

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0, ferr_cnt = 0, perr_cnt = 0, both_cnt = 0;
  logic [7:0] got[$];

  always @(negedge clk) begin
    if (reset_n) begin
      if (rx_done) begin
        done_cnt++;
        got.push_back(data_byte);
      end
      if (frame_err) ferr_cnt++;
      if (parity_err) perr_cnt++;
      if (rx_done && frame_err) both_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic idle(input int n);
    uart_rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n, input int bclk);
    for (int i = 0; i < n; i++) begin
      uart_rx = bits[i];
      repeat (bclk) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic flip_par, input int bclk);
    logic [15:0] bits;
`ifdef UART_RX_PARITY_EN
    bits = 16'({1'b1, (^b) ^ flip_par, b, 1'b0});
`else
    bits = 16'({1'b1, b, 1'b0});
    if (flip_par) bits = 16'({1'b1, b, 1'b0});
`endif
    send_bits(bits, NBITS, bclk);
  endtask

  int d0, f0;

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_data_byte", 32'(data_byte), 32'h00);
    chk("rst_rx_done", 32'(rx_done), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    chk("rst_parity_err", 32'(parity_err), 32'h0);
    chk("rst_uart_state", 32'(uart_state), 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle(BT);

    // 1: single byte
    d0 = done_cnt;
    send_byte(8'hAA, 1'b0, BT);
    idle(BT);
    chk("t1_done_count", 32'(done_cnt - d0), 32'd1);
    chk("t1_data_byte", 32'(data_byte), 32'hAA);
    chk("t1_frame_err", 32'(ferr_cnt), 32'd0);
    chk("t1_uart_state", 32'(uart_state), 32'h0);

    // 2: back-to-back frames, single stop bit
    d0 = done_cnt;
    send_byte(8'h55, 1'b0, BT);
    send_byte(8'h00, 1'b0, BT);
    idle(BT);
    chk("t2_done_count", 32'(done_cnt - d0), 32'd2);
    chk("t2_byte0", 32'(got[d0]), 32'h55);
    chk("t2_byte1", 32'(got[d0 + 1]), 32'h00);

    // 3: 80-clk low glitch is a false start
    d0 = done_cnt;
    f0 = ferr_cnt;
    uart_rx = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("t3_busy_in_glitch", 32'(uart_state), 32'h1);
    repeat (40) @(posedge clk);
    #1;
    idle(2 * BT);
    chk("t3_no_done", 32'(done_cnt - d0), 32'd0);
    chk("t3_no_ferr", 32'(ferr_cnt - f0), 32'd0);
    chk("t3_uart_state", 32'(uart_state), 32'h0);
    send_byte(8'h3C, 1'b0, BT);
    idle(BT);
    chk("t3_next_done", 32'(done_cnt - d0), 32'd1);
    chk("t3_next_byte", 32'(data_byte), 32'h3C);

    // 4: stop bit low, line held low, then recovery
    d0 = done_cnt;
    f0 = ferr_cnt;
    send_bits(16'({8'h00, 1'b0}), NBITS - 1, BT);
    uart_rx = 1'b0;
    repeat (2 * BT) @(posedge clk);
    #1;
    chk("t4_ferr_count", 32'(ferr_cnt - f0), 32'd1);
    chk("t4_no_done", 32'(done_cnt - d0), 32'd0);
    chk("t4_byte_kept", 32'(data_byte), 32'h3C);
    chk("t4_held_in_break", 32'(uart_state), 32'h1);
    idle(BT);
    send_byte(8'h81, 1'b0, BT);
    idle(BT);
    chk("t4_ferr_once", 32'(ferr_cnt - f0), 32'd1);
    chk("t4_next_done", 32'(done_cnt - d0), 32'd1);
    chk("t4_next_byte", 32'(data_byte), 32'h81);

    // 5: reset in the middle of D4 of 0xF0
    d0 = done_cnt;
    send_bits(16'({8'hF0, 1'b0}), 5, BT);
    uart_rx = 1'b1;  // D4 of 0xF0
    repeat (BT / 2) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("t5_rst_data_byte", 32'(data_byte), 32'h00);
    chk("t5_rst_uart_state", 32'(uart_state), 32'h0);
    chk("t5_rst_strobes", 32'({rx_done, frame_err, parity_err}), 32'h0);
    idle(10);
    reset_n = 1'b1;
    idle(2 * BT);
    chk("t5_no_done", 32'(done_cnt - d0), 32'd0);
    send_byte(8'h0F, 1'b0, BT);
    idle(BT);
    chk("t5_next_done", 32'(done_cnt - d0), 32'd1);
    chk("t5_next_byte", 32'(data_byte), 32'h0F);

    // 6: 57600 baud, two bytes from a nominal-rate transmitter
    baud_set = 3'd3;
    idle(BT3);
    d0 = done_cnt;
    send_byte(8'hAA, 1'b0, BT3);
    send_byte(8'h55, 1'b0, BT3);
    idle(BT3);
    chk("t6_done_count", 32'(done_cnt - d0), 32'd2);
    chk("t6_byte0", 32'(got[d0]), 32'hAA);
    chk("t6_byte1", 32'(got[d0 + 1]), 32'h55);
`ifdef UART_RX_PARITY_EN
    d0 = done_cnt;
    f0 = perr_cnt;
    send_byte(8'hA5, 1'b1, BT3);
    idle(BT3);
    chk("t6_par_done", 32'(done_cnt - d0), 32'd1);
    chk("t6_par_err", 32'(perr_cnt - f0), 32'd1);
    chk("t6_par_byte", 32'(data_byte), 32'hA5);
`else
    chk("t6_no_parity_err", 32'(perr_cnt), 32'd0);
`endif

    // baud_set=6 must select 9600 (DIV 325): a 1500-clk low pulse is sampled high at
    // idx 7 (~2600 clk) and rejected; at a faster rate it would start a frame.
    baud_set = 3'd6;
    idle(100);
    d0 = done_cnt;
    f0 = ferr_cnt;
    uart_rx = 1'b0;
    repeat (1500) @(posedge clk);
    #1;
    idle(500);
    chk("t6_9600_in_start", 32'(uart_state), 32'h1);
    idle(5000);
    chk("t6_9600_false_start", 32'(uart_state), 32'h0);
    chk("t6_9600_no_done", 32'(done_cnt - d0), 32'd0);
    chk("t6_9600_no_ferr", 32'(ferr_cnt - f0), 32'd0);

    chk("never_done_and_ferr", 32'(both_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
